inpdt_16_feeder: RTL

//  Operand sequencer and accumulator on the upstream side of the 16-lane signed inner-product unit.
//  - Deserialises paired 9b X/H and W element streams into 144b lane vectors.
//  - Fires the combinational inner-product unit once per 16-element chunk.
//  - Accumulates its 21b result over NUM_CHUNKS chunks.
//  - Presents one full dot product per vector pair to the LSTM gate logic, with a valid/ready handshake.

---
 rtl/inpdt_16_feeder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/inpdt_16_feeder.sv
// rtl/inpdt_16_feeder.sv - operand sequencer and accumulator for the 16-lane inner-product unit
//
// Collects 16 signed 9b X/H and W element pairs into two 144b lane vectors.
// Fires the combinational inner-product unit for one cycle per chunk.
// Accumulates the returned 21b result over NUM_CHUNKS chunks.
// Presents the finished dot product with a valid/ready handshake.
//
// Ports
//   clk       in   1      clock, rising edge
//   resetn    in   1      synchronous active-low reset
//   iValid    in   1      element pair valid
//   oReady    out  1      element pair accepted this cycle when iValid is high
//   iData_X   in   9      signed X/H element
//   iData_W   in   9      signed W element
//   oData_XH  out  144    packed X/H lanes, lane 0 in [143:135]
//   oData_W   out  144    packed W lanes, lane 0 in [143:135]
//   oEn       out  1      inner-product enable (high during FIRE)
//   iResult   in   21     signed inner-product result, combinational return
//   oValid    out  1      dot product available
//   iReady    in   1      downstream accepts the dot product
//   oResult   out  ACC_W  signed dot product
module inpdt_16_feeder #(
    parameter int NUM_CHUNKS = 4,
    parameter int ACC_W      = 24
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               iValid,
    output logic               oReady,
    input  logic [8:0]         iData_X,
    input  logic [8:0]         iData_W,
    output logic [143:0]       oData_XH,
    output logic [143:0]       oData_W,
    output logic               oEn,
    input  logic [20:0]        iResult,
    output logic               oValid,
    input  logic               iReady,
    output logic [ACC_W-1:0]   oResult
);

    localparam int CHUNK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FIRE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [CHUNK_W-1:0]  chunk_q;
    logic [ACC_W-1:0]    acc_q;
    logic [143:0]        data_xh_q;
    logic [143:0]        data_w_q;
    logic                en_q;
    logic                valid_q;
    logic                ready_q;
    logic [ACC_W-1:0]    result_q;

    logic [7:0]          lane_base;
    logic [ACC_W-1:0]    res_ext;
    logic [ACC_W-1:0]    acc_d;
    logic                last_chunk;

    // Lane k sits at bit 144-9*(k+1), so lane 0 is the most significant slot.
    assign lane_base  = (8'd15 - {4'd0, cnt_q}) * 8'd9;

    assign res_ext    = {{(ACC_W-21){iResult[20]}}, iResult};

    // The first chunk restarts the sum, which clears any residue from the previous dot product.
    assign acc_d      = ((chunk_q == '0) ? '0 : acc_q) + res_ext;

    assign last_chunk = (chunk_q == CHUNK_W'(NUM_CHUNKS - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_FILL;
            cnt_q     <= 4'd0;
            chunk_q   <= '0;
            acc_q     <= '0;
            data_xh_q <= '0;
            data_w_q  <= '0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (iValid && ready_q) begin
                        data_xh_q[lane_base +: 9] <= iData_X;
                        data_w_q[lane_base +: 9]  <= iData_W;
                        if (cnt_q == 4'd15) begin
                            cnt_q   <= 4'd0;
                            state_q <= S_FIRE;
                            ready_q <= 1'b0;
                            en_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end

                S_FIRE: begin
                    en_q  <= 1'b0;
                    acc_q <= acc_d;
                    if (last_chunk) begin
                        result_q <= acc_d;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        chunk_q <= chunk_q + CHUNK_W'(1);
                        ready_q <= 1'b1;
                        state_q <= S_FILL;
                    end
                end

                S_DONE: begin
                    if (iReady) begin
                        valid_q <= 1'b0;
                        chunk_q <= '0;
                        ready_q <= 1'b1;
                        state_q <= S_FILL;
                    end
                end

                default: begin
                    state_q <= S_FILL;
                    cnt_q   <= 4'd0;
                    chunk_q <= '0;
                    en_q    <= 1'b0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign oReady   = ready_q;
    assign oEn      = en_q;
    assign oValid   = valid_q;
    assign oData_XH = data_xh_q;
    assign oData_W  = data_w_q;
    assign oResult  = result_q;

endmodule
